// File: rtl/riscv_ctl_pkg.sv
// Shared constants and types for the multicycle RV32I-subset control sequencer.
package riscv_ctl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_REG    = 3'd0,
    C_IMM    = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JUMP   = 3'd5
  } iclass_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] ctl;
  } alu_dec_t;

  // Shared funct3 table for register and immediate ALU forms; sub only matters for funct3 000.
  function automatic alu_dec_t alu_from_funct3(input logic [2:0] funct3, input logic sub);
    alu_dec_t d;
    d.legal = 1'b1;
    d.ctl   = ALU_ADD;
    case (funct3)
      3'b000:  d.ctl = sub ? ALU_SUB : ALU_ADD;
      3'b111:  d.ctl = ALU_AND;
      3'b110:  d.ctl = ALU_OR;
      3'b010:  d.ctl = ALU_SLT;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational instruction decoder: class, ALU operation, operand select and legality.
module ctl_decode
  import riscv_ctl_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [2:0]  iclass,
  output logic [3:0]  aluctl,
  output logic        alusrc,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  alu_dec_t   r_dec;
  alu_dec_t   i_dec;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign funct7_b5   = instruction[30];
  assign r_dec       = alu_from_funct3(funct3, funct7_b5);
  assign i_dec       = alu_from_funct3(funct3, 1'b0);
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  always_comb begin
    iclass = C_REG;
    aluctl = ALU_ADD;
    alusrc = 1'b0;
    legal  = 1'b0;
    case (opcode)
      OP_R: begin
        iclass = C_REG;
        aluctl = r_dec.ctl;
        legal  = r_dec.legal;
      end
      OP_I: begin
        iclass = C_IMM;
        aluctl = i_dec.ctl;
        alusrc = 1'b1;
        legal  = i_dec.legal;
      end
      // Loads and stores add the immediate offset to the base register.
      OP_LW: begin
        iclass = C_LOAD;
        alusrc = 1'b1;
        legal  = (funct3 == 3'b010);
      end
      OP_SW: begin
        iclass = C_STORE;
        alusrc = 1'b1;
        legal  = (funct3 == 3'b010);
      end
      OP_BEQ: begin
        iclass = C_BRANCH;
        aluctl = ALU_SUB;
        legal  = (funct3 == 3'b000);
      end
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        iclass = C_JUMP;
        alusrc = 1'b1;
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter and sticky trap.
module multicycle_control
  import riscv_ctl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instruction,
  input  logic         zero,
  output logic         ir_we,
  output logic         pc_we,
  output logic         branch,
  output logic         mem2reg,
  output logic         memwrite,
  output logic         alusrc,
  output logic         regwrite,
  output logic [3:0]   aluctl,
  output logic         illegal,
  output logic [2:0]   state,
  output logic [W-1:0] instret
);

  state_t        state_reg;
  state_t        state_next;
  iclass_t       class_reg;
  logic [3:0]    aluctl_reg;
  logic          alusrc_reg;
  logic [W-1:0]  instret_reg;

  logic [2:0]    dec_class;
  logic [3:0]    dec_aluctl;
  logic          dec_alusrc;
  logic          dec_legal;
  logic          unused_zero;

  // Branch resolution is done downstream as branch & zero.
  assign unused_zero = zero;

  ctl_decode u_decode (
    .instruction (instruction),
    .iclass      (dec_class),
    .aluctl      (dec_aluctl),
    .alusrc      (dec_alusrc),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      class_reg   <= C_REG;
      aluctl_reg  <= '0;
      alusrc_reg  <= 1'b0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        class_reg  <= iclass_t'(dec_class);
        aluctl_reg <= dec_aluctl;
        alusrc_reg <= dec_alusrc;
      end
      if (pc_we) begin
        instret_reg <= instret_reg + W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    branch     = 1'b0;
    mem2reg    = 1'b0;
    memwrite   = 1'b0;
    alusrc     = 1'b0;
    regwrite   = 1'b0;
    aluctl     = '0;
    case (state_reg)
      S_FETCH: begin
        // Held low while reset is asserted so every output reads 0 during reset.
        ir_we      = ~rst;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        aluctl = aluctl_reg;
        alusrc = alusrc_reg;
        if (class_reg == C_BRANCH) begin
          branch     = 1'b1;
          pc_we      = 1'b1;
          state_next = S_FETCH;
        end else if (class_reg == C_LOAD || class_reg == C_STORE) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        aluctl = aluctl_reg;
        alusrc = alusrc_reg;
        if (class_reg == C_LOAD) begin
          mem2reg    = 1'b1;
          state_next = S_WB;
        end else begin
          memwrite   = 1'b1;
          pc_we      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_WB: begin
        aluctl     = aluctl_reg;
        alusrc     = alusrc_reg;
        mem2reg    = (class_reg == C_LOAD);
        regwrite   = 1'b1;
        pc_we      = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  assign illegal = (state_reg == S_TRAP);
  assign state   = state_reg;
  assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction reference model.
module tb_multicycle_control;

  localparam int W = 4;

  localparam int K_ALU = 0;
  localparam int K_LW  = 1;
  localparam int K_SW  = 2;
  localparam int K_BEQ = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  instruction = '0;
  logic         zero = 1'b0;
  logic         ir_we, pc_we, branch, mem2reg, memwrite, alusrc, regwrite, illegal;
  logic [3:0]   aluctl;
  logic [2:0]   state;
  logic [W-1:0] instret;

  int errors = 0;
  int checks = 0;
  int exp_instret = 0;

  multicycle_control #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .zero        (zero),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .branch      (branch),
    .mem2reg     (mem2reg),
    .memwrite    (memwrite),
    .alusrc      (alusrc),
    .regwrite    (regwrite),
    .aluctl      (aluctl),
    .illegal     (illegal),
    .state       (state),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {state, ir_we, pc_we, branch, mem2reg, memwrite, alusrc, regwrite, aluctl, illegal, 0}
  function automatic logic [31:0] obs();
    return {16'h0, state, ir_we, pc_we, branch, mem2reg, memwrite, alusrc, regwrite,
            aluctl, illegal, 1'b0};
  endfunction

  // Reference decode straight from the instruction tables.
  task automatic ref_decode(input logic [31:0] ins, output bit legal, output int kind,
                            output logic [3:0] ac, output logic as);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    legal = 1'b0; kind = K_ALU; ac = 4'b0010; as = 1'b0;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      as = (op == 7'b0010011);
      legal = 1'b1;
      if (f3 == 3'b000)      ac = (op == 7'b0110011 && ins[30]) ? 4'b0110 : 4'b0010;
      else if (f3 == 3'b111) ac = 4'b0000;
      else if (f3 == 3'b110) ac = 4'b0001;
      else if (f3 == 3'b010) ac = 4'b0111;
      else legal = 1'b0;
    end else if (op == 7'b0000011) begin
      kind = K_LW; as = 1'b1; legal = (f3 == 3'b010);
    end else if (op == 7'b0100011) begin
      kind = K_SW; as = 1'b1; legal = (f3 == 3'b010);
    end else if (op == 7'b1100011) begin
      kind = K_BEQ; ac = 4'b0110; legal = (f3 == 3'b000);
    end else if (op == 7'b1101111 || op == 7'b1100111 || op == 7'b0110111 || op == 7'b0010111) begin
      as = 1'b1; legal = 1'b1;
    end
  endtask

  // Expected outputs for one cycle in phase ph (0 F,1 D,2 E,3 M,4 W,5 TRAP).
  function automatic logic [31:0] exp_vec(input int ph, input bit last, input int kind,
                                          input logic [3:0] ac, input logic as);
    logic [2:0] st;
    logic iw, pw, br, m2r, mw, asrc, rw, ill;
    logic [3:0] actl;
    bit active;
    st     = 3'(ph);
    active = (ph >= 2 && ph <= 4);
    iw     = (ph == 0);
    pw     = last && active;
    br     = (ph == 2) && (kind == K_BEQ);
    m2r    = (kind == K_LW) && (ph == 3 || ph == 4);
    mw     = (ph == 3) && (kind == K_SW);
    rw     = (ph == 4);
    asrc   = active ? as : 1'b0;
    actl   = active ? ac : 4'b0000;
    ill    = (ph == 5);
    return {16'h0, st, iw, pw, br, m2r, mw, asrc, rw, actl, ill, 1'b0};
  endfunction

  // Called at a negedge while the DUT sits in FETCH.
  task automatic run_instr(input logic [31:0] ins);
    bit legal;
    int kind;
    logic [3:0] ac;
    logic as;
    int seq[$];
    ref_decode(ins, legal, kind, ac, as);
    instruction = ins;
    check("instret_start", 32'(instret), 32'(exp_instret % (1 << W)));
    seq = {0, 1};
    if (!legal)               seq = {0, 1, 5, 5, 5, 5};
    else if (kind == K_BEQ)   seq.push_back(2);
    else if (kind == K_LW)    seq = {0, 1, 2, 3, 4};
    else if (kind == K_SW)    seq = {0, 1, 2, 3};
    else                      seq = {0, 1, 2, 4};
    for (int c = 0; c < seq.size(); c++) begin
      check($sformatf("ins=%08h cyc%0d", ins, c + 1), obs(),
            exp_vec(seq[c], (c == seq.size() - 1), kind, ac, as));
      // After DECODE the live instruction word must no longer matter.
      if (c == 2) instruction = $urandom;
      zero = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    if (legal) begin
      exp_instret++;
    end else begin
      check("trap_instret", 32'(instret), 32'(exp_instret % (1 << W)));
      check("trap_stays", obs(), exp_vec(5, 1'b0, kind, ac, as));
      rst = 1'b1;
      #1;
      check("trap_reset_outs", obs(), 32'h0);
      check("trap_reset_instret", 32'(instret), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      exp_instret = 0;
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] op;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      6: op = 7'b1100111;
      7: op = 7'b0110111;
      8: op = 7'b0010111;
      default: op = r[6:0];
    endcase
    r[6:0] = op;
    if ($urandom_range(0, 4) != 0) begin
      if (op == 7'b0110011 || op == 7'b0010011) begin
        case ($urandom_range(0, 3))
          0: r[14:12] = 3'b000;
          1: r[14:12] = 3'b111;
          2: r[14:12] = 3'b110;
          default: r[14:12] = 3'b010;
        endcase
        if (op == 7'b0110011 && r[14:12] != 3'b000) r[30] = 1'b0;
      end else if (op == 7'b0000011 || op == 7'b0100011) begin
        r[14:12] = 3'b010;
      end else if (op == 7'b1100011) begin
        r[14:12] = 3'b000;
      end
    end
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", obs(), 32'h0);
    check("reset_instret", 32'(instret), 32'h0);
    rst = 1'b0;
    #1;
    check("release_fetch", obs(), exp_vec(0, 1'b0, K_ALU, 4'b0, 1'b0));

    // Reset asserted in EXEC: immediate FETCH, no commit.
    instruction = 32'h002081B3;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("exec_before_rst", obs(), exp_vec(2, 1'b0, K_ALU, 4'b0010, 1'b0));
    rst = 1'b1;
    #1;
    check("rst_in_exec_outs", obs(), 32'h0);
    @(posedge clk); @(negedge clk);
    check("rst_in_exec_hold", obs(), 32'h0);
    check("rst_in_exec_instret", 32'(instret), 32'h0);
    rst = 1'b0;
    #1;

    run_instr(32'h002081B3);  // add
    run_instr(32'h402081B3);  // sub
    run_instr(32'h00500093);  // addi
    run_instr(32'h00802283);  // lw
    run_instr(32'h00502623);  // sw
    run_instr(32'h00000463);  // beq
    run_instr(32'h00000000);  // illegal -> trap
    for (int i = 0; i < 18; i++) run_instr(32'h002081B3);  // counter wraps at 2^W
    for (int i = 0; i < 60; i++) run_instr(rand_instr());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control sequencer for the RV32I-subset core. It sits directly upstream of the datapath. It latches the fetched instruction word and decodes opcode/funct3/funct7. It then steps through FETCH/DECODE/EXEC/MEM/WB, driving the datapath control signals (`branch`, `mem2reg`, `memwrite`, `alusrc`, `regwrite`, `aluctl`) plus PC/IR write strobes, so each instruction commits exactly once.

## Interface
- `W`, 32, width of the retired-instruction counter.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `instruction` input 32: instruction word from instruction memory.
- `zero` input 1: ALU zero flag. Informational only; branch resolution happens in the datapath as `branch & zero`.
- `ir_we` output 1: instruction-register write strobe.
- `pc_we` output 1: PC update strobe, one pulse per retired instruction.
- `branch`, `mem2reg`, `memwrite`, `alusrc`, `regwrite` output 1 each: datapath controls.
- `aluctl` output 4: ALU operation code.
- `illegal` output 1: sticky, set on an undecodable instruction.
- `state` output 3: current FSM state, for debug.
- `instret` output W: retired-instruction count.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: assert `ir_we`. Go to DECODE.
- DECODE:
  - Register the instruction class, `aluctl` and `alusrc` from `instruction`. Later changes of `instruction` have no effect until the next DECODE.
  - Go to EXEC if the instruction is legal, otherwise TRAP.
- Classes, by opcode:
  - R 0110011, funct3/funct7[5]:
    - 000/0 → ADD 0010
    - 000/1 → SUB 0110
    - 111 → AND 0000
    - 110 → OR 0001
    - 010 → SLT 0111
  - I-ALU 0010011, same funct3 mapping with `alusrc`=1; funct7 is ignored.
  - LW 0000011 with funct3 010.
  - SW 0100011 with funct3 010.
  - BEQ 1100011 with funct3 000 → SUB, `alusrc`=0.
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111 → ADD, `alusrc`=1.
  - Any other opcode/funct combination is illegal, including 0x00000000.
- Transitions after EXEC:
  - BEQ: EXEC → FETCH.
  - LW: EXEC → MEM → WB → FETCH.
  - SW: EXEC → MEM → FETCH.
  - All others: EXEC → WB → FETCH.
- Control outputs:
  - `aluctl` and `alusrc` hold the decoded values in EXEC, MEM and WB, and are 0 in FETCH, DECODE and TRAP.
  - `branch` is 1 only in EXEC for BEQ.
  - `memwrite` is 1 only in MEM for SW.
  - `mem2reg` is 1 in MEM and WB for LW.
  - `regwrite` is 1 only in WB.
- `pc_we` is asserted in the last state of each instruction: EXEC for BEQ, MEM for SW, WB otherwise.
- `instret` increments by 1 in the cycle `pc_we`=1 and wraps modulo 2^W.
- TRAP:
  - All controls and strobes are 0; `illegal`=1.
  - The FSM stays in TRAP until `rst`.

## Timing
- Reset values: `state`=FETCH; all control outputs, `ir_we`, `pc_we` and `illegal` are 0; `instret`=0.
  - `ir_we` is driven from the state, so it becomes 1 combinationally once reset releases.
- All outputs are Moore outputs of the registered state and decode registers; there are no combinational paths from inputs to outputs.
- Latency in cycles:
  - BEQ: 3.
  - R, I, SW, JAL, JALR, LUI, AUIPC: 4.
  - LW: 5.
- `regwrite`, `memwrite` and `pc_we` are each a single-cycle pulse per instruction, and never overlap with `ir_we`.
- Reset asserted mid-instruction:
  - Immediate return to FETCH with all outputs 0.
  - No partial commit; `instret` is cleared.

## Structure
- Package `riscv_ctl_pkg`:
  - opcode constants;
  - `aluctl` codes (AND, OR, ADD, SUB, SLT, NOR = 1100);
  - state encoding;
  - instruction-class enumeration.
- One combinational sub-module, `ctl_decode`: takes `instruction` and produces class, `aluctl`, `alusrc` and legal. The FSM and counter live in `multicycle_control`.

## Test plan
- Reset, then release `rst` → `state`=0 and `ir_we`=1. Assert `rst` in EXEC → `state`=0 immediately, no `regwrite`.
- `add x3,x1,x2` (0x002081B3), then `sub` (0x402081B3):
  - `aluctl` 0010 then 0110 in EXEC;
  - `regwrite` pulse in cycle 4;
  - `instret`=2 after 8 cycles.
- `addi x1,x0,5` (0x00500093) → `alusrc`=1, `aluctl`=0010, 4 cycles.
- `lw x5,8(x0)` (0x00802283) → `mem2reg`=1 in MEM and WB, `regwrite` only in cycle 5.
- `sw x5,12(x0)` (0x00502623) → `memwrite` only in MEM (cycle 4), no `regwrite`.
- `beq x0,x0,+8` (0x00000463) → `branch`=1 and `pc_we`=1 in cycle 3, back in FETCH at cycle 4.
- Instruction 0x00000000 → TRAP:
  - `illegal`=1 stays set;
  - `pc_we` is never asserted;
  - `instret` is unchanged.
